merge9_leaf: RTL and testbench
==============================

Name: merge9_leaf

Overview:
- Reverse-direction companion to the 9-bit split/decoder leaf of the NoC tree.
- Merges two upstream 9-bit packet channels into one downstream channel using round-robin arbitration.
- Reports which input won on a 1-bit select channel S, sent before the packet itself; this is the same S-then-Out ordering the decoder leaf uses.
- Packet format is unchanged and the block does not interpret it: [8:5] address, [4:0] payload.

Parameters:
- W, 9, packet width in bits.
- CNT_W, 16, width of the grant counters (used only when MERGE_STATS_EN is defined).

Ports:
- CLK  in  1  clock, rising edge.
- _RESET  in  1  synchronous, active-low reset.
- In0_data  in  W  packet from input 0.
- In0_valid  in  1  input 0 offers a packet.
- In0_ready  out  1  input 0 packet accepted this cycle.
- In1_data  in  W  packet from input 1.
- In1_valid  in  1  input 1 offers a packet.
- In1_ready  out  1  input 1 packet accepted this cycle.
- S_data  out  1  winning input index.
- S_valid  out  1  S token valid.
- S_ready  in  1  downstream accepts S.
- Out_data  out  W  merged packet.
- Out_valid  out  1  packet valid.
- Out_ready  in  1  downstream accepts packet.
- Grant0_cnt  out  CNT_W  input-0 grants (MERGE_STATS_EN only).
- Grant1_cnt  out  CNT_W  input-1 grants (MERGE_STATS_EN only).

Behaviour:
- One clock, CLK. Reset is synchronous and active-low, sampled on the rising edge of CLK.
- Reset state: state=IDLE, prio=0, data_q=0, win_q=0. All outputs are 0: In*_ready, S_valid, S_data, Out_valid, Out_data.
- A transfer on any channel occurs when valid && ready at a rising edge.
- Sources hold valid and data stable until the transfer. A source dropping valid early is a protocol violation.
- FSM states:
  - IDLE:
    - grant = 0 if only In0_valid is set; 1 if only In1_valid is set; prio if both are set.
    - In{grant}_ready = 1, combinational from the valids. The other ready = 0. With no valid, both readies = 0.
    - On a transfer: data_q<=In{grant}_data; win_q<=grant; prio<=~grant; go to SEND_S.
  - SEND_S:
    - S_valid=1, S_data=win_q; both In*_ready=0.
    - On S_ready: go to SEND_OUT.
  - SEND_OUT:
    - Out_valid=1, Out_data=data_q; both In*_ready=0.
    - On Out_ready: go to IDLE.
- Latency and throughput:
  - Input accept at edge N gives S_valid in cycle N+1.
  - With S_ready=Out_ready=1 throughout: Out_valid in cycle N+2, next accept at edge N+3.
  - Throughput is 1 packet per 3 cycles at best.
- S is never valid in the same cycle as Out.
- Out_data and S_data hold their values while stalled.
- Fairness: prio only updates on an accepted grant. Under continuous contention, grants strictly alternate.
- A single requester wins regardless of prio. Its win still sets prio to the other input.
- Backpressure on S or Out blocks both inputs. Nothing is dropped or reordered.
- Reset mid-operation (SEND_S or SEND_OUT): the held packet is discarded, outputs drop at the next edge, and prio returns to 0.
- In*_ready never depends on S_ready or Out_ready. No combinational path exists from downstream to upstream.

Optional Feature:
- Macro: MERGE_STATS_EN.
- Defined:
  - Grant0_cnt and Grant1_cnt increment on each accepted grant for their input.
  - Counters saturate at 2^CNT_W-1; they do not wrap.
  - Counters reset to 0 on _RESET.
- Undefined: both counter ports are tied to 0, no counter registers exist, and all other behaviour is identical.

Test Plan:
- Single source: In0 sends 9'h1A5 with S_ready=Out_ready=1.
  - In0_ready in cycle 0; S_valid/S_data=0 in cycle 1; Out_valid/Out_data=9'h1A5 in cycle 2; IDLE in cycle 3.
- Contention after reset: In0=9'h0F0 and In1=9'h10F valid together and held.
  - Out order: 9'h0F0 (S=0), 9'h10F (S=1), then alternating while both stay valid.
- Backpressure: S_ready=0 for 4 cycles, then Out_ready=0 for 3 cycles.
  - S_valid held 4 cycles, then Out_valid held 3 cycles with data stable.
  - In0_ready=In1_ready=0 throughout the stall; no loss.
- Reset in SEND_OUT: _RESET=0 for 1 edge while Out_valid=1.
  - Next cycle Out_valid=0 and Out_data=0; prio returns to 0, so a subsequent contention goes to In0 first.
- MERGE_STATS_EN with CNT_W=2: 5 grants to In1.
  - Grant1_cnt reads 1,2,3,3,3 and Grant0_cnt stays 0.
  - With the macro undefined, both counters stay 0.

Source files
------------

// File: rtl/merge9_leaf.sv
// Round-robin merge of two 9-bit packet channels onto one output; the winning input index goes out on S before the packet.
// Optional grant counters are built only when MERGE_STATS_EN is defined.
module merge9_leaf #(
    parameter int W     = 9,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             _RESET,
    input  logic [W-1:0]     In0_data,
    input  logic             In0_valid,
    output logic             In0_ready,
    input  logic [W-1:0]     In1_data,
    input  logic             In1_valid,
    output logic             In1_ready,
    output logic             S_data,
    output logic             S_valid,
    input  logic             S_ready,
    output logic [W-1:0]     Out_data,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [CNT_W-1:0] Grant0_cnt,
    output logic [CNT_W-1:0] Grant1_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_S   = 2'd1,
        SEND_OUT = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic           prio_reg, prio_next;
    logic           win_reg, win_next;
    logic [W-1:0]   data_reg, data_next;
    logic           grant;
    logic           accept;

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        grant = prio_reg;
        if (In0_valid && !In1_valid)
            grant = 1'b0;
        else if (In1_valid && !In0_valid)
            grant = 1'b1;
    end

    // Readies depend only on upstream valids, state and reset, never on downstream readies.
    assign accept    = _RESET && (state_reg == IDLE) && (In0_valid || In1_valid);
    assign In0_ready = accept && !grant;
    assign In1_ready = accept && grant;

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            win_reg   <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            win_reg   <= win_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        win_next   = win_reg;
        data_next  = data_reg;
        S_valid    = 1'b0;
        Out_valid  = 1'b0;
        S_data     = win_reg;
        Out_data   = data_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next  = grant ? In1_data : In0_data;
                    win_next   = grant;
                    prio_next  = ~grant;
                    state_next = SEND_S;
                end
            end
            SEND_S: begin
                S_valid = 1'b1;
                if (S_ready)
                    state_next = SEND_OUT;
            end
            SEND_OUT: begin
                Out_valid = 1'b1;
                if (Out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MERGE_STATS_EN
    logic [1:0] grant_hit;
    assign grant_hit = {In1_ready, In0_ready};

    // Saturating per-input grant counters.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge CLK) begin
            if (!_RESET)
                cnt_reg <= '0;
            else if (grant_hit[gi] && (cnt_reg != {CNT_W{1'b1}}))
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign Grant0_cnt = g_cnt[0].cnt_reg;
    assign Grant1_cnt = g_cnt[1].cnt_reg;
`else
    assign Grant0_cnt = '0;
    assign Grant1_cnt = '0;
`endif

endmodule

// File: tb/tb_merge9_leaf.sv
// Randomised scoreboard bench for merge9_leaf: a queue-based model predicts readies, S tokens and packets.
// Grant counter expectations follow MERGE_STATS_EN.
module tb_merge9_leaf;

    localparam int W        = 9;
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                CLK;
    logic                rst_n;
    logic [W-1:0]        d0, d1;
    logic                v0, v1;
    logic                In0_ready, In1_ready;
    logic                S_data, S_valid, sr;
    logic [W-1:0]        Out_data;
    logic                Out_valid, orr;
    logic [TB_CNT_W-1:0] Grant0_cnt, Grant1_cnt;

    merge9_leaf #(.W(W), .CNT_W(TB_CNT_W)) dut (
        .CLK        (CLK),
        ._RESET     (rst_n),
        .In0_data   (d0),
        .In0_valid  (v0),
        .In0_ready  (In0_ready),
        .In1_data   (d1),
        .In1_valid  (v1),
        .In1_ready  (In1_ready),
        .S_data     (S_data),
        .S_valid    (S_valid),
        .S_ready    (sr),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_ready  (orr),
        .Grant0_cnt (Grant0_cnt),
        .Grant1_cnt (Grant1_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending S tokens and packets; inputs are accepted only when nothing is pending.
    int  sq[$];
    int  oq[$];
    bit  m_prio = 0;
    int  m_cnt0 = 0;
    int  m_cnt1 = 0;
    bit  tx0 = 0, tx1 = 0;

    always @(negedge CLK) begin
        bit busy, g, e_r0, e_r1, e_sv, e_ov;
        int e_c0, e_c1;
        busy = (sq.size() > 0) || (oq.size() > 0);
        g = m_prio;
        if (v0 && !v1) g = 0;
        else if (v1 && !v0) g = 1;
        e_r0 = rst_n && !busy && v0 && (g == 0);
        e_r1 = rst_n && !busy && v1 && (g == 1);
        e_sv = sq.size() > 0;
        e_ov = (sq.size() == 0) && (oq.size() > 0);
`ifdef MERGE_STATS_EN
        e_c0 = m_cnt0;
        e_c1 = m_cnt1;
`else
        e_c0 = 0;
        e_c1 = 0;
`endif
        check("in0_ready", In0_ready, e_r0);
        check("in1_ready", In1_ready, e_r1);
        check("s_valid", S_valid, e_sv);
        check("out_valid", Out_valid, e_ov);
        if (e_sv) check("s_data", S_data, sq[0]);
        if (e_ov) check("out_data", Out_data, oq[0]);
        check("grant0_cnt", Grant0_cnt, e_c0);
        check("grant1_cnt", Grant1_cnt, e_c1);

        tx0 = 0;
        tx1 = 0;
        if (!rst_n) begin
            sq.delete();
            oq.delete();
            m_prio = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (e_sv && sr) void'(sq.pop_front());
            else if (e_ov && orr) void'(oq.pop_front());
            if (e_r0 || e_r1) begin
                sq.push_back(int'(g));
                oq.push_back(g ? int'(d1) : int'(d0));
                m_prio = !g;
                if (g) begin
                    tx1 = 1;
                    if (m_cnt1 < CNT_MAX) m_cnt1++;
                end else begin
                    tx0 = 1;
                    if (m_cnt0 < CNT_MAX) m_cnt0++;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (tx0) v0 = 1'b0;
        if (tx1) v1 = 1'b0;
    endtask

    task automatic wait_taken(input string name, input int which);
        int n;
        n = 0;
        while (((which == 0) ? v0 : v1) && n < 50) begin
            step();
            n++;
        end
        check(name, n < 50, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
        sr = 1'b1; orr = 1'b1;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) step();
        @(negedge CLK);
        check("rst_s_data", S_data, 0);
        check("rst_out_data", Out_data, 0);
        rst_n = 1'b1;
        step();

        // Five grants to In1 alone (counter saturation)
        for (int k = 0; k < 5; k++) begin
            v1 = 1'b1;
            d1 = W'($urandom);
            wait_taken("cnt_grant", 1);
        end
        repeat (3) step();

        // Single source, fixed packet
        v0 = 1'b1;
        d0 = 9'h1A5;
        wait_taken("single", 0);
        repeat (3) step();

        // Contention right after a reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (!v0) begin v0 = 1'b1; d0 = 9'h0F0; end
            if (!v1) begin v1 = 1'b1; d1 = 9'h10F; end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) step();

        // Backpressure: S stalled 4 cycles, then Out stalled 3 cycles, both inputs pending
        sr = 1'b0; orr = 1'b0;
        v0 = 1'b1; d0 = W'($urandom);
        v1 = 1'b1; d1 = W'($urandom);
        step();
        repeat (3) step();
        sr = 1'b1;
        step();
        repeat (2) step();
        orr = 1'b1;
        step();
        wait_taken("bp_in0", 0);
        wait_taken("bp_in1", 1);
        repeat (3) step();

        // Reset while a packet is held in the output stage
        orr = 1'b0;
        v0 = 1'b1; d0 = W'($urandom);
        begin
            int n;
            n = 0;
            while (!Out_valid && n < 20) begin
                step();
                n++;
            end
            check("reach_send_out", Out_valid, 1);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        orr = 1'b1;
        @(negedge CLK);
        check("rst_out_valid", Out_valid, 0);
        check("rst_out_data", Out_data, 0);
        v0 = 1'b1; d0 = W'($urandom);
        v1 = 1'b1; d1 = W'($urandom);
        wait_taken("post_rst_in0", 0);
        wait_taken("post_rst_in1", 1);

        // Random traffic with random backpressure
        for (int k = 0; k < 800; k++) begin
            if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1'b1; d0 = W'($urandom); end
            if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1'b1; d1 = W'($urandom); end
            sr  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain
        sr = 1'b1; orr = 1'b1;
        for (int k = 0; k < 20 && (v0 || v1); k++) step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (8) step();
        @(negedge CLK);
        check("drained", sq.size() + oq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
